// File: rtl/bus_rbtr_rr.sv
// Shared-bus arbiter: grants one device FIFO at a time (round-robin or fixed priority),
// routes the packet by its destination ID with back-pressure, broadcast and drop counting.
module bus_rbtr_rr #(
  parameter int unsigned drvrs     = 4,
  parameter int unsigned pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF,
  parameter int unsigned cnt_w     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  input  logic [drvrs-1:0]           full,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  input  logic                       arb_mode,
  output logic                       busy,
  output logic [3:0]                 grant_id,
  output logic [cnt_w-1:0]           drop_cnt
);

  localparam int unsigned IdxW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {StIdle, StPop, StDeliver, StDrop} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     src_q, src_d;
  logic [pckg_sz-1:0]  pkt_q, pkt_d;
  logic [drvrs-1:0]    tgt_q, tgt_d;

  logic [drvrs-1:0]    pop_d, push_d;
  logic [pckg_sz-1:0]  d_push_d;
  logic                busy_d;
  logic [3:0]          grant_id_d;
  logic [cnt_w-1:0]    drop_cnt_d;

  logic [IdxW-1:0]     win, rr_idx;
  logic                win_vld;
  logic [7:0]          dst;
  logic [drvrs-1:0]    tgt_dec;

  // Winner select; loops run downward so the last hit is the first in search order.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    rr_idx  = '0;
    if (arb_mode) begin
      for (int i = int'(drvrs) - 1; i >= 0; i--) begin
        if (pndng[IdxW'(i)]) begin
          win     = IdxW'(i);
          win_vld = 1'b1;
        end
      end
    end else begin
      for (int i = int'(drvrs); i >= 1; i--) begin
        rr_idx = IdxW'((int'(rr_ptr_q) + i) % int'(drvrs));
        if (pndng[rr_idx]) begin
          win     = rr_idx;
          win_vld = 1'b1;
        end
      end
    end
  end

  // Target decode of the latched packet; src never receives its own packet.
  always_comb begin
    dst     = pkt_q[pckg_sz-1 -: 8];
    tgt_dec = '0;
    if (dst == broadcast) begin
      tgt_dec        = '1;
      tgt_dec[src_q] = 1'b0;
    end else if ((32'(dst) < drvrs) && (dst[IdxW-1:0] != src_q)) begin
      tgt_dec[dst[IdxW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= IdxW'(drvrs - 1);
      src_q    <= '0;
      pkt_q    <= '0;
      tgt_q    <= '0;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      drop_cnt <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      pkt_q    <= pkt_d;
      tgt_q    <= tgt_d;
      pop      <= pop_d;
      push     <= push_d;
      D_push   <= d_push_d;
      busy     <= busy_d;
      grant_id <= grant_id_d;
      drop_cnt <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (win_vld) state_d = StPop;
      StPop:     state_d = (tgt_dec == '0) ? StDrop : StDeliver;
      StDeliver: if (push != '0) state_d = StIdle;
      StDrop:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Registered outputs: push is raised on the edge after targets are seen not full,
  // and the state leaves DELIVER on the edge that ends the push cycle.
  always_comb begin
    pop_d      = '0;
    push_d     = '0;
    d_push_d   = D_push;
    busy_d     = (state_d != StIdle);
    grant_id_d = grant_id;
    drop_cnt_d = drop_cnt;
    rr_ptr_d   = rr_ptr_q;
    src_d      = src_q;
    pkt_d      = pkt_q;
    tgt_d      = tgt_q;
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          pop_d[win] = 1'b1;
          pkt_d      = D_pop[win*pckg_sz +: pckg_sz];
          src_d      = win;
          rr_ptr_d   = win;
          grant_id_d = 4'(win);
        end
      end
      StPop: begin
        tgt_d = tgt_dec;
        if (tgt_dec != '0) begin
          d_push_d = pkt_q;
          if ((full & tgt_dec) == '0) push_d = tgt_dec;
        end
      end
      StDeliver: begin
        if ((push == '0) && ((full & tgt_q) == '0)) push_d = tgt_q;
      end
      StDrop: begin
        if (drop_cnt != {cnt_w{1'b1}}) drop_cnt_d = drop_cnt + cnt_w'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/bus_rbtr_rr.md
# bus_rbtr_rr

Parametrised successor to the single-bus generator/arbiter. It arbitrates `drvrs` device FIFOs onto one shared bus and routes each packet by an 8-bit destination ID in the packet MSBs. It adds:
- runtime-selectable round-robin or fixed-priority arbitration;
- receiver back-pressure;
- broadcast excluding the sender;
- counting of dropped packets.

It sits between the per-device FIFO models (driven through `bus_if`) and the device receive FIFOs.

## Interface
Parameters:
- `drvrs`, 4, number of attached devices (2..16)
- `pckg_sz`, 16, packet width in bits (≥ 9)
- `broadcast`, 8'hFF, destination ID meaning "all devices except sender"
- `cnt_w`, 8, width of the drop counter

Ports:
- `clk`  input  1  bus clock, all logic on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `pndng`  input  drvrs  device i has a packet at its FIFO head
- `D_pop`  input  drvrs*pckg_sz  FIFO head data, device i at bits [i*pckg_sz +: pckg_sz]
- `pop`  output  drvrs  one-cycle pulse dequeuing device i's FIFO head
- `full`  input  drvrs  device i's receive FIFO cannot accept a push
- `push`  output  drvrs  one-cycle pulse writing `D_push` into device i
- `D_push`  output  pckg_sz  packet being delivered
- `arb_mode`  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- `busy`  output  1  high whenever FSM is not IDLE
- `grant_id`  output  4  index of the last granted source
- `drop_cnt`  output  cnt_w  saturating count of dropped packets

## Operation
- Destination `dst = pkt[pckg_sz-1 -: 8]`. `src` is the granted index.
- FSM states: IDLE, POP, DELIVER, DROP.

IDLE:
- If `pndng != 0`, pick winner `w`. Latch `D_pop[w]` into `pkt`, set `grant_id = w`, go to POP.
- Otherwise stay in IDLE.

Arbitration:
- Fixed priority: lowest set `pndng` bit.
- Round-robin: first set bit searching from `rr_ptr+1` upward, wrapping modulo `drvrs`.
- `rr_ptr` is updated to `w` on every grant, in both modes. Reset value of `rr_ptr` is `drvrs-1`, so device 0 wins first.
- `arb_mode` is sampled only in IDLE. A change mid-transfer affects the next grant only.

POP:
- `pop[w] = 1` for exactly one cycle.
- Decode target mask `tgt`:
  - `dst == broadcast`: all devices except `src`.
  - `dst < drvrs` and `dst != src`: one-hot `dst`.
  - Otherwise: `tgt = 0`.
- If `tgt == 0`, go to DROP. Otherwise go to DELIVER.

DELIVER:
- If `(full & tgt) != 0`, stall: `push = 0`, `D_push` holds `pkt`.
- Else assert `push = tgt` for one cycle, `D_push = pkt`, then go to IDLE.
- Broadcast is all-or-nothing: no partial delivery.

DROP:
- `drop_cnt` increments by 1, saturating at 2^cnt_w - 1, then go to IDLE.
- `push` stays 0.

Other rules:
- `D_push` holds its last value when `push == 0`. It is updated only on entry to DELIVER.
- Async reset mid-transfer: the in-flight packet is discarded (it was already popped if past POP) and is not counted as a drop. FSM returns to IDLE.

## Timing
- Reset values: `pop = 0`, `push = 0`, `D_push = 0`, `busy = 0`, `grant_id = 0`, `drop_cnt = 0`, FSM = IDLE, `rr_ptr = drvrs-1`.
- Outputs are registered. All outputs go to reset values asynchronously on `reset` low.
- `pndng` sampled high at edge k: `pop` high in cycle k+1; `push` high in cycle k+2 if no `full`; FSM back in IDLE in cycle k+3.
- Peak throughput: one packet per 3 cycles. Each stall cycle in DELIVER adds one cycle.
- Dropped packet: `drop_cnt` is updated at the end of cycle k+2; no `push` is issued.
- `pndng` changing during POP/DELIVER is ignored until the next IDLE.
- `pndng[w]` must not be re-sampled for the popped packet: the FIFO advances on the edge that ends `pop`.
- `busy` is high from cycle k+1 through the last non-IDLE cycle.

## Test plan
- Round-robin fairness:
  - Stimulus: `arb_mode = 0`, all 4 devices pending continuously, each packet with `dst = (src+1)%4`.
  - Required: grants in order 0,1,2,3,0; one `push` every 3 cycles; each packet arrives at `src+1`.
- Fixed priority:
  - Stimulus: `arb_mode = 1`, devices 1 and 3 pending, device 1 holds 2 packets.
  - Required: grants in order 1,1,3.
- Broadcast:
  - Stimulus: device 2 sends `16'hFF5A`.
  - Required: `push = 4'b1011` for one cycle with `D_push = 16'hFF5A`; `drop_cnt` unchanged.
- Back-pressure:
  - Stimulus: device 0 sends `16'h0312`; `full[3]` held high for 5 cycles.
  - Required: `push` is delayed 5 cycles and then `push = 4'b1000`; `D_push` is stable throughout; `busy` stays high.
- Drops and saturation:
  - Stimulus: packets with `dst = 8'h07` and `dst == src`; also `cnt_w = 2` with 5 bad packets.
  - Required: no `push`; `drop_cnt` reaches 3 and holds at 3.
- Reset mid-transfer:
  - Stimulus: assert `reset = 0` in the cycle `pop` is high.
  - Required: all outputs go to 0 immediately; after release, the first grant goes to device 0; `drop_cnt = 0`.
